// File: rtl/text_buffer.sv
// text_buffer: cursor-driven text RAM feeding console; define TEXT_BUFFER_SCROLL_EN for hardware scrolling
module text_buffer #(
    parameter int COLUMNS = 80,
    parameter int ROWS = 30,
    parameter int CHAR_WIDTH = 8,
    parameter int CHAR_HEIGHT = 16,
    parameter int FRAME_WIDTH = 800,
    parameter int FRAME_HEIGHT = 525,
    parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
    input  logic        clk_pixel,
    input  logic        RESETn,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    output logic [7:0]  codepoint,
    output logic [7:0]  attribute,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);
    localparam int CELLS = ROWS * COLUMNS;
    localparam int AW = $clog2(CELLS);
    localparam int CWL = $clog2(CHAR_WIDTH);
    localparam int CHL = $clog2(CHAR_HEIGHT);
    localparam logic [10:0] FW = 11'(FRAME_WIDTH);
    localparam logic [10:0] FH = 11'(FRAME_HEIGHT);

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t state;
    logic [AW-1:0] cnt, raddr, raddr_q, caddr, waddr;
    logic [10:0] lx_sum, lx, ly_inc, ly, col, row;
    logic wrap, vis, vis_q, vis_q2, we, accept, is_cr, is_lf, is_bs, print, adv;
    logic [4:0] rprow, cprow;
    logic [15:0] wdata, rd_q;
    logic [15:0] mem [CELLS];

    // Lookahead pixel two clocks ahead, folded across line and frame ends, mapped to a cell
    always_comb begin
        lx_sum = {1'b0, cx} + 11'd2;
        wrap = lx_sum >= FW;
        lx = wrap ? lx_sum - FW : lx_sum;
        ly_inc = {1'b0, cy} + 11'd1;
        ly = wrap ? (ly_inc >= FH ? '0 : ly_inc) : {1'b0, cy};
        col = lx >> CWL;
        row = ly >> CHL;
        vis = col < 11'(COLUMNS) && row < 11'(ROWS);
    end

`ifdef TEXT_BUFFER_SCROLL_EN
    logic [4:0] top_row;
    logic [5:0] rsum, csum;
    assign rsum = {1'b0, row[4:0]} + {1'b0, top_row};
    assign csum = {1'b0, cursor_y} + {1'b0, top_row};
    assign rprow = rsum >= 6'(ROWS) ? 5'(rsum - 6'(ROWS)) : rsum[4:0];
    assign cprow = csum >= 6'(ROWS) ? 5'(csum - 6'(ROWS)) : csum[4:0];
`else
    assign rprow = row[4:0];
    assign cprow = cursor_y;
`endif

    assign raddr = vis ? AW'(int'(rprow) * COLUMNS + int'(col)) : '0;
    assign caddr = AW'(int'(cprow) * COLUMNS + int'(cursor_x));
    assign accept = wr_valid && wr_ready;
    assign is_cr = wr_data[7:0] == 8'h0D;
    assign is_lf = wr_data[7:0] == 8'h0A;
    assign is_bs = wr_data[7:0] == 8'h08;
    assign print = !(is_cr || is_lf || is_bs);
    assign adv = is_lf || (print && cursor_x == 7'(COLUMNS - 1));

    // Write port: INIT sweeps every cell, CLEAR sweeps the cursor's physical row, IDLE stores printables
    always_comb begin
        we = state != IDLE || (accept && print);
        waddr = state == INIT ? cnt : state == CLEAR ? AW'(int'(cprow) * COLUMNS + int'(cnt)) : caddr;
        wdata = state == IDLE ? wr_data : {DEFAULT_ATTR, 8'h20};
    end

    // Control FSM: fill sequencing, character decode, cursor motion and line advance
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            state <= INIT;
            cnt <= '0;
            wr_ready <= 1'b0;
            cursor_x <= '0;
            cursor_y <= '0;
`ifdef TEXT_BUFFER_SCROLL_EN
            top_row <= '0;
`endif
        end else if (state != IDLE) begin
            if (cnt == (state == INIT ? AW'(CELLS - 1) : AW'(COLUMNS - 1))) begin
                cnt <= '0;
                state <= IDLE;
                wr_ready <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (accept) begin
            cursor_x <= (is_cr || adv) ? '0 : is_bs ? (cursor_x != '0 ? cursor_x - 1'b1 : cursor_x) : cursor_x + 1'b1;
            if (adv) begin
                if (cursor_y < 5'(ROWS - 1)) begin
                    cursor_y <= cursor_y + 1'b1;
                end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
                    top_row <= top_row == 5'(ROWS - 1) ? '0 : top_row + 1'b1;
`else
                    cursor_y <= '0;
`endif
                    state <= CLEAR;
                    wr_ready <= 1'b0;
                end
            end
        end
    end

    // Display pipeline stage 1: registered read address and visibility
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            raddr_q <= '0;
            vis_q <= 1'b0;
            vis_q2 <= 1'b0;
        end else begin
            raddr_q <= raddr;
            vis_q <= vis;
            vis_q2 <= vis_q;
        end
    end

    // Simple dual-port RAM with registered read (stage 2)
    always_ff @(posedge clk_pixel) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[raddr_q];
    end

    assign codepoint = vis_q2 ? rd_q[7:0] : 8'h20;
    assign attribute = vis_q2 ? rd_q[15:8] : 8'h00;
endmodule

// File: doc/text_buffer.md
# text_buffer

Text-mode character store that feeds `console` with `codepoint` and `attribute` for the pixel being drawn. It sits directly upstream of `console` in the `clk_pixel` domain and reads the same `cx`/`cy` counters that `hdmi` produces. A write-side stream handshake accepts characters and control codes. The block manages a cursor, line wrap and hardware scrolling, so a producer such as the SAM or JTAG bridge can print text without computing addresses.

## Interface
Parameters:
- COLUMNS, 80, character cells per row
- ROWS, 30, character rows
- CHAR_WIDTH, 8, glyph width in pixels (power of 2)
- CHAR_HEIGHT, 16, glyph height in pixels (power of 2)
- FRAME_WIDTH, 800, total pixels per line including blanking
- FRAME_HEIGHT, 525, total lines per frame including blanking
- DEFAULT_ATTR, 8'h0F, attribute written by clear operations

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- RESETn  in  1  asynchronous, active-low reset
- cx  in  10  current pixel x from `hdmi`
- cy  in  10  current pixel y from `hdmi`
- codepoint  out  8  character at (cx, cy); to `console`
- attribute  out  8  attribute at (cx, cy); to `console`
- wr_valid  in  1  write request
- wr_ready  out  1  block can accept a write
- wr_data  in  16  {attribute[15:8], codepoint[7:0]}
- cursor_x  out  7  current cursor column
- cursor_y  out  5  current cursor row

## Operation
- Storage is a simple dual-port RAM of ROWS*COLUMNS 16-bit words. The write port is owned by the FSM. The read port is owned by the display pipeline.
- Display read:
  - Lookahead coordinate is lx = cx+2 and ly = cy.
  - If cx+2 >= FRAME_WIDTH, then lx = cx+2-FRAME_WIDTH and ly = cy+1, with ly wrapping to 0 at FRAME_HEIGHT.
  - Cell index is (lx/CHAR_WIDTH, ly/CHAR_HEIGHT).
  - Physical row = (logical row + top_row) mod ROWS.
  - A cell outside COLUMNS×ROWS outputs codepoint 8'h20 and attribute 8'h00.
- FSM states:
  - INIT: after reset, writes 8'h20/DEFAULT_ATTR to all ROWS*COLUMNS cells, one per cycle; wr_ready=0; then goes to IDLE.
  - IDLE: wr_ready=1. An accepted write (wr_valid && wr_ready) is decoded as follows:
    - 8'h0D: cursor_x←0.
    - 8'h0A: cursor_x←0, then advance line.
    - 8'h08: if cursor_x>0, cursor_x←cursor_x-1; no erase.
    - Any other codepoint: write wr_data to (cursor_x, cursor_y), then cursor_x←cursor_x+1. If the result equals COLUMNS, cursor_x←0 and advance line.
  - CLEAR: writes 8'h20/DEFAULT_ATTR to the COLUMNS cells of one physical row; wr_ready=0; returns to IDLE.
- Advance line:
  - If cursor_y<ROWS-1, cursor_y←cursor_y+1.
  - Otherwise top_row←(top_row+1) mod ROWS. cursor_y stays at ROWS-1. Enter CLEAR on the new bottom physical row, which is the old top_row.
- All counter arithmetic uses modulo compares against the parameters, never power-of-2 truncation. COLUMNS and ROWS need not be powers of two.

## Timing
- Reset values:
  - codepoint=8'h20, attribute=8'h00
  - wr_ready=0
  - cursor_x=0, cursor_y=0, top_row=0
  - state=INIT
- Display latency is 2 cycles: address register, then RAM output register. Because of the +2 lookahead, the output in cycle t belongs to the pixel cx(t), provided cx steps by 1 per clock.
- wr_ready is a registered function of state only; it never depends on wr_valid combinationally.
- A write accepted in cycle t is in RAM at t+1. It is visible on codepoint/attribute no later than t+3. A same-address read-during-write may return old data.
- CLEAR lasts exactly COLUMNS cycles; wr_ready rises in the cycle after the last clear write. INIT lasts exactly ROWS*COLUMNS cycles.
- An assertion of RESETn=0 mid-INIT, mid-CLEAR or mid-write aborts immediately to reset values. RAM contents are then rebuilt by INIT.
- At most one write is accepted per cycle, and none while wr_ready=0.

## Configuration
- TEXT_BUFFER_SCROLL_EN defined:
  - Scrolling operates as described above: top_row advances and CLEAR blanks the new bottom row.
- TEXT_BUFFER_SCROLL_EN undefined:
  - top_row is constant 0.
  - Advance line at cursor_y=ROWS-1 sets cursor_y←0 and enters CLEAR on row 0. Text wraps to the top and overwrites.
  - The scroll adder and modulo logic on the read path are removed.

## Test plan
- Reset release: wr_ready stays 0 for exactly 2400 cycles, then goes to 1. Scanning the full frame gives 8'h20/8'h0F for every visible cell and 8'h20/8'h00 outside 640×480.
- Write 16'h1F41: for cx=0..7, cy=0..15 the outputs are codepoint 8'h41 and attribute 8'h1F; cx=8 gives 8'h20. cursor_x=1, cursor_y=0.
- Write 80 printable characters: cursor ends at (0,1). The 80th character is at cell (79,0).
- Fill rows 0–29 with row-unique characters, then send 8'h0A at cursor_y=29:
  - wr_ready is low for exactly 80 cycles.
  - Screen row 0 shows the former row 1, and row 28 shows the former row 29.
  - Row 29 is blank, and the cursor is at (0,29).
- Lookahead wrap with distinct rows 0 and 1: at cy=15 the change is visible exactly at cx=0 of cy=16. The row 0 content is unaffected at cx=798..799 of cy=15.
- Control codes:
  - At (5,3), 8'h0D moves the cursor to (0,3).
  - 8'h08 at x=0 leaves the cursor unchanged.
  - 8'h08 at x=4 moves it to x=3.
  - No cell contents change in any of these cases.
